// File: rtl/rv_sender_if.sv
// rv_sender_if: single-beat ready/valid channel between a producer (master)
// and a receiver controller (slave). The producer drives out_valid/out_data,
// the receiver drives in_ready.
interface rv_sender_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             in_ready;

  modport master (
    output out_valid,
    output out_data,
    input  in_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output in_ready
  );
endinterface

// File: rtl/rv_sender.sv
// rv_sender: producer end of the single-beat ready/valid channel.
// A local source pushes words into a DEPTH-entry circular FIFO. The head word
// is presented on the channel and held stable until the receiver takes it.
// Every output comes from registered state; push and in_ready only steer the
// next-state logic.
// Optional feature macro: RV_SENDER_STALL_CNT_EN adds a saturating 16-bit
// stall_count (cycles with out_valid=1 and in_ready=0).
//
// state  | meaning
// EMPTY  | count = 0, out_valid low, out_data forced to 0
// ACTIVE | 0 < count < DEPTH, head word on the channel
// FULL   | count = DEPTH, new pushes rejected and flagged in overflow
module rv_sender #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNTW-1:0]          xfer_count,
  output logic                     overflow,
`ifdef RV_SENDER_STALL_CNT_EN
  output logic [15:0]              stall_count,
`endif
  rv_sender_if.master              ch
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             enq;
  logic             deq;

  // Accept/transfer decisions use only pre-edge registered state, so a push
  // while full is rejected even when a dequeue frees a slot on the same edge.
  always_comb begin
    enq = push && (state != FULL);
    deq = (state != EMPTY) && ch.in_ready;
  end

  // Next occupancy and the control state it implies.
  always_comb begin
    count_nxt = count_q;
    case ({enq, deq})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase

    if (count_nxt == '0) begin
      state_nxt = EMPTY;
    end else if (count_nxt == DEPTH_C) begin
      state_nxt = FULL;
    end else begin
      state_nxt = ACTIVE;
    end
  end

  // Storage write; contents need no reset since they are masked while empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and control state; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      state   <= EMPTY;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_nxt;
      state   <= state_nxt;
    end
  end

  // Completed-transfer counter, wraps modulo 2^CNTW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_count <= '0;
    end else if (deq) begin
      xfer_count <= xfer_count + CNTW'(1);
    end
  end

  // Sticky flag for a push attempted while full; cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (push && (state == FULL)) begin
      overflow <= 1'b1;
    end
  end

`ifdef RV_SENDER_STALL_CNT_EN
  // Backpressure cycles while holding a word, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if ((state != EMPTY) && !ch.in_ready && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

  // Channel and status outputs straight from registered state.
  always_comb begin
    ch.out_valid = (state != EMPTY);
    ch.out_data  = (state != EMPTY) ? mem[rd_ptr] : '0;
    full         = (state == FULL);
    count        = count_q;
  end
endmodule
